dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the data memory. Port 0 is the core load/store path and port 1 is an auxiliary master (debug loader/DMA). The block accepts one request at a time, issues it as a single-cycle read/write strobe, and tracks the memory's stall handshake to completion. It then returns read data and a completion pulse to the winning port, with a watchdog for accesses the memory never acknowledges.

## Interface
- PRIORITY_MODE, 0: 0 = round-robin between ports; 1 = fixed, port 0 always wins.
- TIMEOUT, 8: maximum cycles in WAIT_HI before the access is aborted with an error (range 2..255).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid, req1_valid  in  1  request present on port N.
- req0_ready, req1_ready  out  1  request accepted this cycle (combinational from state and inputs).
- req0_addr, req1_addr  in  32  byte address.
- req0_wdata, req1_wdata  in  32  store data.
- req0_write, req1_write  in  1  1 = store, 0 = load.
- req0_sign_mask, req1_sign_mask  in  4  size/sign code, passed through unchanged.
- resp0_valid, resp1_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp*_valid; 1 = timeout.
- mem_addr, mem_wdata  out  32  held command to memory.
- mem_sign_mask  out  4  held size/sign code.
- mem_read, mem_write  out  1  one-cycle command strobe.
- mem_rdata  in  32  memory read data.
- mem_stall  in  1  memory busy.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - Grant only when mem_stall==0.
  - Winner: in PRIORITY_MODE 1, port 0 if valid, else port 1. In mode 0, a lone valid port wins; if both are valid, the port not in last_grant wins.
  - reqN_ready=1 for the winner only.
  - On valid&&ready, capture addr/wdata/write/sign_mask and the port id, update last_grant, go to ISSUE.
- ISSUE: assert mem_write if write=1, else mem_read, for exactly this cycle. Clear the timer. Go to WAIT_HI.
- WAIT_HI:
  - If mem_stall==1, go to WAIT_LO.
  - Otherwise increment the timer. When the timer reaches TIMEOUT-1, go to RESP with err=1 and rdata=0.
- WAIT_LO: on mem_stall==0, capture mem_rdata (loads) or 0 (stores) and go to RESP with err=0.
- RESP: pulse resp{id}_valid, drive resp_rdata/resp_err from registers, go to IDLE.
- mem_addr/mem_wdata/mem_sign_mask are registered. They hold the captured values from ISSUE until the next capture.
- Reset values: state IDLE, last_grant=1 (port 0 wins the first tie), all outputs 0, timer 0.

## Timing
- Accept (IDLE) in cycle t, strobe in t+1. Against a memory asserting stall for 2 cycles, capture happens in t+4 and resp_valid in t+5. The earliest next accept is t+6.
- Throughput: one access per 6 cycles with that memory. Back-to-back requests from both ports alternate in mode 0.
- mem_read and mem_write are never both 1, and are never high outside ISSUE.
- resp_rdata/resp_err are valid only while a resp*_valid is high. Otherwise they hold their last value.
- Requests that arrive while the block is not in IDLE see ready=0 and must be held by the requester.
- Simultaneous valid on both ports in IDLE: exactly one ready.
- If mem_stall==1 in IDLE (e.g. after a reset mid-access), no grant is made until it falls.
- Reset asserted mid-transaction: state returns to IDLE immediately and outputs clear. No response is produced for the dropped request.
- Timeout: at TIMEOUT=8 with stall stuck low, resp occurs 8 cycles after WAIT_HI entry, i.e. t+10.

## Test plan
- Load on port 0 only: addr 0x4004, memory model stalls 2 cycles and returns 0xDEADBEEF → req0_ready at t, mem_read high only at t+1, resp0_valid at t+5 with resp_rdata=0xDEADBEEF and resp_err=0.
- Store on port 1: addr 0x4010, wdata 0x12345678, sign_mask 0x2 → mem_write pulse with mem_wdata=0x12345678 and mem_sign_mask=0x2 held through WAIT_LO; resp1_valid with resp_rdata=0.
- Both ports hold valid for 4 accesses in mode 0 → grant order 0,1,0,1. In mode 1 the order is 0,0,0,0 and port 1 is served only after port 0 drops valid.
- Memory model never stalls, TIMEOUT=8 → resp_err=1 and resp_rdata=0 at t+10, then the next request is accepted normally.
- rst_n low during WAIT_LO → all outputs 0 asynchronously and no resp pulse. With mem_stall still high after release, no grant until it falls.
- Request valid while mem_stall=1 in IDLE → ready stays 0 until the cycle mem_stall=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one request at a time, issues a one-cycle
// read/write strobe, follows the memory stall handshake and returns a response pulse.
module dmem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_write,
  input  logic [3:0]  req0_sign_mask,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_write,
  input  logic [3:0]  req1_sign_mask,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  sign_mask;
  } req_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_e      state_q;
  req_t [1:0]  req;
  logic [1:0]  vld, win, rdy, resp_vld_q;
  logic        last_grant_q, id_q, write_q, sel, accept;
  logic [7:0]  timer_q;
  logic        mem_read_q, mem_write_q, resp_err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, resp_rdata_q;
  logic [3:0]  mem_sign_mask_q;

  assign vld    = {req1_valid, req0_valid};
  assign req[0] = {req0_addr, req0_wdata, req0_write, req0_sign_mask};
  assign req[1] = {req1_addr, req1_wdata, req1_write, req1_sign_mask};

  // On a tie in round-robin mode the port that did not win last time goes next.
  always_comb begin
    win = 2'b00;
    if (PRIORITY_MODE == 1) win = vld[0] ? 2'b01 : {vld[1], 1'b0};
    else if (&vld)          win = last_grant_q ? 2'b01 : 2'b10;
    else                    win = vld;
  end

  assign rdy    = (rst_n && state_q == S_IDLE && !mem_stall) ? win : 2'b00;
  assign accept = |rdy;
  assign sel    = rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      last_grant_q    <= 1'b1;
      id_q            <= 1'b0;
      write_q         <= 1'b0;
      timer_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_sign_mask_q <= '0;
      resp_vld_q      <= '0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          mem_addr_q      <= req[sel].addr;
          mem_wdata_q     <= req[sel].wdata;
          mem_sign_mask_q <= req[sel].sign_mask;
          write_q         <= req[sel].write;
          mem_write_q     <= req[sel].write;
          mem_read_q      <= !req[sel].write;
          id_q            <= sel;
          last_grant_q    <= sel;
          state_q         <= S_ISSUE;
        end
        S_ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (mem_stall) state_q <= S_WAIT_LO;
          else if (timer_q == TMAX) begin
            resp_rdata_q     <= '0;
            resp_err_q       <= 1'b1;
            resp_vld_q[id_q] <= 1'b1;
            state_q          <= S_RESP;
          end else timer_q <= timer_q + 8'd1;
        end
        S_WAIT_LO: if (!mem_stall) begin
          resp_rdata_q     <= write_q ? 32'd0 : mem_rdata;
          resp_err_q       <= 1'b0;
          resp_vld_q[id_q] <= 1'b1;
          state_q          <= S_RESP;
        end
        S_RESP: begin
          resp_vld_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready    = rdy[0];
  assign req1_ready    = rdy[1];
  assign resp0_valid   = resp_vld_q[0];
  assign resp1_valid   = resp_vld_q[1];
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_sign_mask = mem_sign_mask_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: instance 0 is round-robin (TIMEOUT 8), instance 1
// is fixed-priority (TIMEOUT 5); a transaction-level model predicts grants and latencies.
module tb_dmem_arbiter;
  logic        clk;
  logic        rst_n [2];
  logic        rv    [2][2];
  logic        rrdy  [2][2];
  logic [31:0] ra    [2][2];
  logic [31:0] rw    [2][2];
  logic        rwr   [2][2];
  logic [3:0]  rm    [2][2];
  logic        rsv   [2][2];
  logic [31:0] rdat  [2];
  logic        rerr  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [3:0]  mmask [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic [31:0] mrdat [2];
  logic        mst   [2];

  int n_chk = 0;
  int n_err = 0;
  int last [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.PRIORITY_MODE(g), .TIMEOUT(g == 0 ? 8 : 5)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req0_valid(rv[g][0]), .req0_ready(rrdy[g][0]), .req0_addr(ra[g][0]),
      .req0_wdata(rw[g][0]), .req0_write(rwr[g][0]), .req0_sign_mask(rm[g][0]),
      .req1_valid(rv[g][1]), .req1_ready(rrdy[g][1]), .req1_addr(ra[g][1]),
      .req1_wdata(rw[g][1]), .req1_write(rwr[g][1]), .req1_sign_mask(rm[g][1]),
      .resp0_valid(rsv[g][0]), .resp1_valid(rsv[g][1]),
      .resp_rdata(rdat[g]), .resp_err(rerr[g]),
      .mem_addr(maddr[g]), .mem_wdata(mwd[g]), .mem_sign_mask(mmask[g]),
      .mem_read(mrd[g]), .mem_write(mwr[g]),
      .mem_rdata(mrdat[g]), .mem_stall(mst[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int tmo(input int d);
    return d == 0 ? 8 : 5;
  endfunction

  // Reference arbitration rule: mode equals the instance index.
  function automatic int pick(input int d);
    if (d == 1) return rv[d][0] ? 0 : 1;
    if (rv[d][0] && rv[d][1]) return last[d] == 0 ? 1 : 0;
    return rv[d][0] ? 0 : 1;
  endfunction

  function automatic logic [31:0] rdy2(input int d);
    return 32'({rrdy[d][1], rrdy[d][0]});
  endfunction

  function automatic logic [31:0] rsp2(input int d);
    return 32'({rsv[d][1], rsv[d][0]});
  endfunction

  task automatic new_req(input int d, input int p);
    rv[d][p]  = 1'b1;
    ra[d][p]  = $urandom;
    rw[d][p]  = $urandom;
    rwr[d][p] = 1'($urandom_range(0, 1));
    rm[d][p]  = 4'($urandom_range(0, 15));
  endtask

  // One complete access: idle (optionally stalled), grant, strobe, wait, response.
  task automatic access(input int d);
    int w, dl, s, len;
    bit to;
    logic [31:0] md, ea, ew;
    logic        ewr;
    logic [3:0]  em;
    if (!rv[d][0] && !rv[d][1]) new_req(d, $urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        mst[d] = 1'b1;
        @(negedge clk);
        chk("idle_stall_ready", rdy2(d), 32'd0);
        step();
      end
    end
    mst[d] = 1'b0;
    w = pick(d);
    @(negedge clk);
    chk("grant", rdy2(d), (w == 0) ? 32'd1 : 32'd2);
    ea = ra[d][w]; ew = rw[d][w]; ewr = rwr[d][w]; em = rm[d][w];
    last[d] = w;
    step();
    rv[d][w] = 1'b0;
    if ($urandom_range(0, 1) == 1) new_req(d, w);
    to  = ($urandom_range(0, 4) == 0);
    dl  = $urandom_range(0, 3);
    s   = $urandom_range(1, 3);
    md  = $urandom;
    mrdat[d] = md;
    len = to ? 2 + tmo(d) : 3 + dl + s;
    @(negedge clk);
    chk("strobe_rd", 32'(mrd[d]), 32'(!ewr));
    chk("strobe_wr", 32'(mwr[d]), 32'(ewr));
    chk("mem_addr", maddr[d], ea);
    chk("mem_wdata", mwd[d], ew);
    chk("mem_mask", 32'(mmask[d]), 32'(em));
    chk("busy_ready", rdy2(d), 32'd0);
    step();
    for (int c = 2; c <= len; c++) begin
      mst[d] = !to && (c - 2 >= dl) && (c - 2 < dl + s);
      @(negedge clk);
      if (c < len) begin
        chk("no_strobe", 32'({mrd[d], mwr[d]}), 32'd0);
        chk("no_resp", rsp2(d), 32'd0);
        chk("busy_ready", rdy2(d), 32'd0);
      end else begin
        chk("resp_valid", rsp2(d), (w == 0) ? 32'd1 : 32'd2);
        chk("resp_rdata", rdat[d], (to || ewr) ? 32'd0 : md);
        chk("resp_err", 32'(rerr[d]), 32'(to));
        chk("held_addr", maddr[d], ea);
        chk("held_mask", 32'(mmask[d]), 32'(em));
      end
      step();
    end
    mst[d] = 1'b0;
  endtask

  // Reset during WAIT_LO, then release with the memory still stalled.
  task automatic reset_mid(input int d);
    rv[d][1] = 1'b0;
    new_req(d, 0);
    ra[d][0] = 32'h4004; rw[d][0] = 32'hA5A5_0001; rwr[d][0] = 1'b0; rm[d][0] = 4'h3;
    mst[d] = 1'b0;
    @(negedge clk);
    chk("rst_pre_grant", rdy2(d), 32'd1);
    step();
    rv[d][0] = 1'b0;
    mst[d] = 1'b1;
    step();
    step();
    #2 rst_n[d] = 1'b0;
    #1;
    chk("rst_mem_addr", maddr[d], 32'd0);
    chk("rst_mem_wdata", mwd[d], 32'd0);
    chk("rst_mem_mask", 32'(mmask[d]), 32'd0);
    chk("rst_strobes", 32'({mrd[d], mwr[d]}), 32'd0);
    chk("rst_resp", rsp2(d), 32'd0);
    chk("rst_rdata_err", 32'({rerr[d], 31'd0}) | rdat[d], 32'd0);
    new_req(d, 0);
    new_req(d, 1);
    step();
    rst_n[d] = 1'b1;
    last[d] = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_after_rst_ready", rdy2(d), 32'd0);
      chk("stall_after_rst_resp", rsp2(d), 32'd0);
      step();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; mst[d] = 1'b0; mrdat[d] = '0; last[d] = 1;
      for (int p = 0; p < 2; p++) begin
        rv[d][p] = 1'b0; ra[d][p] = '0; rw[d][p] = '0; rwr[d][p] = 1'b0; rm[d][p] = '0;
      end
    end
    #3;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    step();
    step();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_strobes", 32'({mrd[d], mwr[d]}), 32'd0);
      chk("reset_resp", rsp2(d), 32'd0);
      chk("reset_mem_addr", maddr[d], 32'd0);
      chk("reset_rdata", rdat[d], 32'd0);
      chk("reset_err", 32'(rerr[d]), 32'd0);
    end
    step();
    for (int d = 0; d < 2; d++) begin
      new_req(d, 0);
      new_req(d, 1);
      repeat (40) access(d);
      reset_mid(d);
      repeat (10) access(d);
      rv[d][0] = 1'b0;
      rv[d][1] = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
